// File: rtl/alu_seq_if.sv
// Issue/result bundle between the execute stage and the sequential ALU.
// The master drives the operation; the slave returns result and status.
interface alu_seq_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [4:0]       sel;
    logic             byte_mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;
    logic             busy;
    logic             done;
    logic             illegal;

    modport master (
        output start, sel, byte_mode, a, b,
        input  result, flags, busy, done, illegal
    );

    modport slave (
        input  start, sel, byte_mode, a, b,
        output result, flags, busy, done, illegal
    );
endinterface

// File: rtl/alu_seq_core.sv
// Registered ALU with status word {N,Z,C,V}, byte mode, BCD add,
// rotate-through-carry and a multi-cycle shift-add multiplier.
module alu_seq_core #(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input logic      clk,
    input logic      rst_n,
    alu_seq_if.slave bus
);
    typedef enum logic {IDLE, MUL} state_t;

    localparam int NN = WIDTH / 4;
    localparam int CW = $clog2(WIDTH);

    localparam logic [4:0] OP_MOV  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADDC = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SUBC = 5'd4;
    localparam logic [4:0] OP_CMP  = 5'd5;
    localparam logic [4:0] OP_DADD = 5'd6;
    localparam logic [4:0] OP_BIT  = 5'd7;
    localparam logic [4:0] OP_BIC  = 5'd8;
    localparam logic [4:0] OP_BIS  = 5'd9;
    localparam logic [4:0] OP_XOR  = 5'd10;
    localparam logic [4:0] OP_AND  = 5'd11;
    localparam logic [4:0] OP_CLR  = 5'd12;
    localparam logic [4:0] OP_MUL  = 5'd13;
    localparam logic [4:0] OP_RRC  = 5'd14;

    function automatic logic msb(input logic [WIDTH-1:0] x, input logic bm);
        return bm ? x[7] : x[WIDTH-1];
    endfunction

    state_t             state;
    logic [WIDTH-1:0]   r_q;
    logic [3:0]         f_q;
    logic               busy_q, done_q, ill_q;
    logic [2*WIDTH-1:0] m_acc, m_cand, prod;
    logic [WIDTH-1:0]   m_plier, p_low, m_mask;
    logic [CW-1:0]      m_cnt, m_last;
    logic               m_byte, hi_nz;

    logic [WIDTH-1:0] mask, av, bv, res_c, dres;
    logic [WIDTH:0]   sum;
    logic [4:0]       nib;
    logic             sub, cin, cy, sa, sb, dc;
    logic             cflag, vflag, upd_r, upd_f, ill, is_mul;
    logic [3:0]       nf;

    assign bus.result  = r_q;
    assign bus.flags   = f_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.illegal = ill_q;

    always_comb begin
        mask = bus.byte_mode ? {{(WIDTH-8){1'b0}}, 8'hFF} : '1;
        av   = bus.a & mask;
        bv   = bus.b & mask;
        sub  = (bus.sel == OP_SUB) || (bus.sel == OP_SUBC) ||
               (bus.sel == OP_CMP);
        if (bus.sel == OP_ADD)
            cin = 1'b0;
        else if (bus.sel == OP_ADDC || bus.sel == OP_SUBC)
            cin = f_q[1];
        else
            cin = 1'b1;
        sum = {1'b0, av} + {1'b0, sub ? (~bus.b & mask) : bv}
            + {{WIDTH{1'b0}}, cin};
        cy  = bus.byte_mode ? sum[8] : sum[WIDTH];
        sa  = msb(av, bus.byte_mode);
        sb  = msb(bv, bus.byte_mode);

        // Decimal adjust nibble by nibble, rippling the decimal carry.
        dc   = f_q[1];
        dres = '0;
        nib  = '0;
        for (int i = 0; i < NN; i++) begin
            if (!bus.byte_mode || i < 2) begin
                nib = {1'b0, bus.a[4*i +: 4]} + {1'b0, bus.b[4*i +: 4]}
                    + {4'b0, dc};
                if (nib > 5'd9) begin
                    nib = nib + 5'd6;
                    dc  = 1'b1;
                end else begin
                    dc  = 1'b0;
                end
                dres[4*i +: 4] = nib[3:0];
            end
        end

        res_c  = r_q;
        cflag  = f_q[1];
        vflag  = 1'b0;
        upd_r  = 1'b0;
        upd_f  = 1'b0;
        ill    = 1'b0;
        is_mul = 1'b0;
        unique case (bus.sel)
            OP_MOV: begin
                res_c = bv;
                upd_r = 1'b1;
            end
            OP_ADD, OP_ADDC: begin
                res_c = sum[WIDTH-1:0] & mask;
                cflag = cy;
                vflag = (sa == sb) && (msb(res_c, bus.byte_mode) != sa);
                upd_r = 1'b1;
                upd_f = 1'b1;
            end
            OP_SUB, OP_SUBC, OP_CMP: begin
                res_c = sum[WIDTH-1:0] & mask;
                cflag = cy;
                vflag = (sa != sb) && (msb(res_c, bus.byte_mode) != sa);
                upd_r = (bus.sel != OP_CMP);
                upd_f = 1'b1;
            end
            OP_DADD: begin
                res_c = dres;
                cflag = dc;
                upd_r = 1'b1;
                upd_f = 1'b1;
            end
            OP_BIT, OP_AND: begin
                res_c = av & bv;
                cflag = (res_c != '0);
                upd_r = (bus.sel == OP_AND);
                upd_f = 1'b1;
            end
            OP_XOR: begin
                res_c = av ^ bv;
                cflag = (res_c != '0);
                vflag = sa & sb;
                upd_r = 1'b1;
                upd_f = 1'b1;
            end
            OP_BIC: begin
                res_c = av & ~bv;
                upd_r = 1'b1;
            end
            OP_BIS: begin
                res_c = av | bv;
                upd_r = 1'b1;
            end
            OP_CLR: begin
                res_c = '0;
                upd_r = 1'b1;
            end
            OP_MUL: begin
                is_mul = MUL_EN;
                ill    = !MUL_EN;
            end
            OP_RRC: begin
                res_c = (av >> 1) & mask;
                if (bus.byte_mode)
                    res_c[7] = f_q[1];
                else
                    res_c[WIDTH-1] = f_q[1];
                cflag = bus.a[0];
                upd_r = 1'b1;
                upd_f = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        nf = {msb(res_c, bus.byte_mode), res_c == '0, cflag, vflag};
    end

    always_comb begin
        prod   = m_acc + (m_plier[0] ? m_cand : '0);
        m_mask = m_byte ? {{(WIDTH-8){1'b0}}, 8'hFF} : '1;
        p_low  = prod[WIDTH-1:0] & m_mask;
        hi_nz  = m_byte ? (prod[2*WIDTH-1:8] != '0)
                        : (prod[2*WIDTH-1:WIDTH] != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            r_q     <= '0;
            f_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ill_q   <= 1'b0;
            m_acc   <= '0;
            m_cand  <= '0;
            m_plier <= '0;
            m_cnt   <= '0;
            m_last  <= '0;
            m_byte  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    ill_q  <= 1'b0;
                    if (bus.start && is_mul) begin
                        state   <= MUL;
                        busy_q  <= 1'b1;
                        m_acc   <= '0;
                        m_cand  <= {{WIDTH{1'b0}}, av};
                        m_plier <= bv;
                        m_cnt   <= '0;
                        m_last  <= bus.byte_mode ? CW'(7) : CW'(WIDTH-1);
                        m_byte  <= bus.byte_mode;
                    end else if (bus.start) begin
                        done_q <= 1'b1;
                        ill_q  <= ill;
                        if (upd_r) r_q <= res_c;
                        if (upd_f) f_q <= nf;
                    end
                end
                MUL: begin
                    m_acc   <= prod;
                    m_cand  <= m_cand << 1;
                    m_plier <= m_plier >> 1;
                    m_cnt   <= m_cnt + 1'b1;
                    if (m_cnt == m_last) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        r_q    <= p_low;
                        f_q    <= {msb(p_low, m_byte), p_low == '0,
                                   hi_nz, 1'b0};
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/alu_seq_core.md
Name: alu_seq_core

Overview:
Parametrised, registered successor of the datapath's 16-bit combinational ALU. It adds a start/busy/done handshake, a registered status word {N,Z,C,V} with per-op update rules, byte mode, a multi-cycle shift-add multiplier and rotate-through-carry. The execute stage of the CPU instantiates it: operand A is the destination, operand B is the source.

Parameters:
WIDTH, 16, datapath width in bits; must be even and >= 8.
MUL_EN, 1, 1 enables the MUL op; 0 makes sel 01101 illegal.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  issue request; sampled on a rising edge while busy=0
sel  input  5  operation code, sampled with start
byte_mode  input  1  1 = operate on bits [7:0] only, sampled with start
a  input  WIDTH  destination operand
b  input  WIDTH  source operand
result  output  WIDTH  registered result
flags  output  4  registered status {N,Z,C,V}
busy  output  1  high while a multi-cycle op is in progress
done  output  1  one-cycle pulse: result/flags valid this cycle
illegal  output  1  one-cycle pulse with done for an unsupported sel

Behaviour:
- Reset (rst_n=0, asynchronous): result=0, flags=0000, busy=0, done=0, illegal=0, FSM=IDLE, multiplier registers cleared. A reset that arrives mid-MUL aborts the MUL and no done pulse is produced.
- FSM states: IDLE, MUL. While in MUL, start is ignored (no queueing).
- Single-cycle ops: start=1 in IDLE at edge k registers result and flags at edge k. done=1 during cycle k..k+1. Latency is 1.
- Arithmetic: all arithmetic is done at width W (W = 8 in byte mode, else WIDTH) plus a carry bit.
  - Sign bit is bit W-1.
  - In byte mode, result[WIDTH-1:8] = 0.
- Carry convention: C = carry out of bit W-1. For subtraction, C=1 means no borrow.
- Opcodes, with the flags each one updates:
  - 00000 MOV: result=b. Flags unchanged.
  - 00001 ADD: a+b. Flags NZCV.
  - 00010 ADDC: a+b+C. Flags NZCV.
  - 00011 SUB: a+~b+1. Flags NZCV.
  - 00100 SUBC: a+~b+C. Flags NZCV.
  - 00101 CMP: computes a+~b+1. Flags NZCV; result register unchanged.
  - 00110 DADD: BCD add of a+b+C, per nibble. C = decimal carry out of the top nibble; N and Z from the result; V=0.
  - 00111 BIT: computes a&b. N, Z, C=~Z, V=0; result unchanged.
  - 01000 BIC: a&~b. Flags unchanged.
  - 01001 BIS: a|b. Flags unchanged.
  - 01010 XOR: a^b. N, Z, C=~Z, V = a[W-1]&b[W-1].
  - 01011 AND: a&b. N, Z, C=~Z, V=0.
  - 01100 CLR: result=0. Flags unchanged.
  - 01101 MUL: unsigned a*b (multi-cycle, see below).
  - 01110 RRC: {C, a[W-1:1]}. New C = a[0]; N and Z from result; V=0.
- Flag formulas:
  - N = result[W-1].
  - Z = (result[W-1:0] == 0).
  - Add overflow: V = (a_s == b_s) & (r_s != a_s).
  - Subtract overflow: V = (a_s != b_s) & (r_s != a_s).
  - Here a_s, b_s and r_s are the sign bits of a, b and the result.
- MUL (operation):
  - start at edge k latches a and b; busy=1 from edge k.
  - One shift-add step per cycle for W cycles.
  - At edge k+W: busy=0, done=1, result = low W bits of the product.
- MUL (flags): C = (high W bits != 0), N and Z from the low half, V=0. Back-to-back issue is allowed in the cycle after done.
- Illegal sel: any unlisted code, or 01101 with MUL_EN=0.
  - done=1 and illegal=1 at edge k.
  - result and flags unchanged; busy stays 0.
- start=0: done and illegal return to 0; result and flags hold indefinitely.

Test Plan:
- Reset: hold rst_n=0 mid-MUL -> result=0x0000, flags=0000, busy=0 immediately (no clock needed); no done after release.
- ADD: a=0x7FFF, b=0x0001 -> result=0x8000, flags N=1 Z=0 C=0 V=1, done pulse 1 cycle after start. Then SUB with a=0x0005, b=0x0005 -> result=0x0000, Z=1, C=1, N=0, V=0.
- Byte mode ADD: a=0x12FF, b=0x0001 -> result=0x0000, flags Z=1 C=1 V=0 N=0. Then ADDC with a=0x0001, b=0x0001 -> result=0x0003.
- MUL: a=0x0100, b=0x0100 -> busy high for exactly 16 cycles, done at edge 16, result=0x0000, C=1, Z=1. A start pulsed during busy is ignored: exactly one done pulse occurs.
- CMP/BIT/MOV flag rules: CMP a=3, b=5 -> result unchanged, N=1 C=0. BIT a=0x00F0, b=0x000F -> Z=1 C=0. MOV b=0x8000 -> result=0x8000, flags unchanged.
- Illegal: sel=11111 -> done=1 and illegal=1 for one cycle, result and flags unchanged. Same with sel=01101 under MUL_EN=0.
